// File: rtl/apb_master.sv
// APB requester: valid/ready command in, SETUP/ACCESS transfer out, one-cycle response strobe.
// Define APB_MASTER_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES wait cycles.
module apb_master #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY
);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_t;

  state_t state, state_nx;
  logic   accept;
  logic   done;
  logic   abort;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  assign req_ready = (state == IDLE);
  assign PSEL      = (state != IDLE);
  assign PENABLE   = (state == ACCESS);
  assign accept    = req_valid && req_ready;
  assign done      = (state == ACCESS) && PREADY;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CNT_W-1:0] cnt;

  // Abort on the edge that ends the TIMEOUT_CYCLES-th stalled ACCESS cycle.
  assign abort = (state == ACCESS) && !PREADY &&
                 (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      cnt <= '0;
    end else if (state == SETUP) begin
      cnt <= '0;
    end else if ((state == ACCESS) && !PREADY) begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      rsp_err <= 1'b0;
    end else if (done) begin
      rsp_err <= 1'b0;
    end else if (abort) begin
      rsp_err <= 1'b1;
    end
  end
`else
  assign abort   = 1'b0;
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept) state_nx = SETUP;
      SETUP:   state_nx = ACCESS;
      ACCESS:  if (done || abort) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= done || abort;
      if (accept) begin
        PWRITE <= req_write;
        PADDR  <= req_addr;
        PWDATA <= req_wdata;
      end
      if (done) begin
        rsp_rdata <= PWRITE ? '0 : PRDATA;
      end else if (abort) begin
        rsp_rdata <= '0;
      end
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// Self-checking bench for apb_master: scripted and random transfers against a memory model.
// Timeout expectations follow APB_MASTER_TIMEOUT_EN with TIMEOUT_CYCLES = 4.
module tb_apb_master;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic          PCLK;
  logic          PRESETn;
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          PSEL;
  logic          PENABLE;
  logic          PWRITE;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA;
  logic [DW-1:0] PRDATA;
  logic          PREADY;

  int            n_pass;
  int            n_total;
  logic [DW-1:0] ref_mem [16];
  logic [DW-1:0] slv_mem [16];
  logic [DW-1:0] last_rdata;
  logic          last_err;

  apb_master #(
    .ADDR_W(AW),
    .DATA_W(DW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .PCLK(PCLK),
    .PRESETn(PRESETn),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .PSEL(PSEL),
    .PENABLE(PENABLE),
    .PWRITE(PWRITE),
    .PADDR(PADDR),
    .PWDATA(PWDATA),
    .PRDATA(PRDATA),
    .PREADY(PREADY)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  // Tasks start and end 1 time unit after a rising edge.
  task automatic do_xfer(input logic wr, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata, input int waits,
                         input logic setup_rdy, input string nm);
    logic [DW-1:0] exp_rd;
    exp_rd = wr ? '0 : ref_mem[addr[3:0]];
    if (wr) ref_mem[addr[3:0]] = wdata;
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
    @(negedge PCLK);
    n_total++;
    if ({req_ready, rsp_valid, rsp_rdata, rsp_err} !== {1'b1, 1'b0, last_rdata, last_err})
      $display("FAIL %s idle: got %h want %h", nm,
               {req_ready, rsp_valid, rsp_rdata, rsp_err}, {1'b1, 1'b0, last_rdata, last_err});
    else n_pass++;
    @(posedge PCLK); #1;
    req_valid = 1'b0;
    req_addr  = $urandom;
    req_wdata = $urandom;
    PREADY    = setup_rdy;
    PRDATA    = $urandom;
    @(negedge PCLK);
    n_total++;
    if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA, req_ready, rsp_valid} !==
        {1'b1, 1'b0, wr, addr, wdata, 1'b0, 1'b0})
      $display("FAIL %s setup: got %h want %h", nm,
               {PSEL, PENABLE, PWRITE, PADDR, PWDATA, req_ready, rsp_valid},
               {1'b1, 1'b0, wr, addr, wdata, 1'b0, 1'b0});
    else n_pass++;
    @(posedge PCLK); #1;
    for (int i = 0; i <= waits; i++) begin
      PREADY = (i == waits);
      PRDATA = (!wr && i == waits) ? slv_mem[addr[3:0]] : $urandom;
      @(negedge PCLK);
      n_total++;
      if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA, req_ready, rsp_valid} !==
          {1'b1, 1'b1, wr, addr, wdata, 1'b0, 1'b0})
        $display("FAIL %s access%0d: got %h want %h", nm, i,
                 {PSEL, PENABLE, PWRITE, PADDR, PWDATA, req_ready, rsp_valid},
                 {1'b1, 1'b1, wr, addr, wdata, 1'b0, 1'b0});
      else n_pass++;
      if (i == waits && PWRITE) slv_mem[PADDR[3:0]] = PWDATA;
      @(posedge PCLK); #1;
    end
    PREADY = 1'b0;
    PRDATA = $urandom;
    @(negedge PCLK);
    n_total++;
    if ({rsp_valid, rsp_err, rsp_rdata, PSEL, PENABLE, req_ready} !==
        {1'b1, 1'b0, exp_rd, 1'b0, 1'b0, 1'b1})
      $display("FAIL %s rsp: got %h want %h", nm,
               {rsp_valid, rsp_err, rsp_rdata, PSEL, PENABLE, req_ready},
               {1'b1, 1'b0, exp_rd, 1'b0, 1'b0, 1'b1});
    else n_pass++;
    last_rdata = exp_rd;
    last_err   = 1'b0;
    @(posedge PCLK); #1;
  endtask

  task automatic test_reset();
    PRESETn   = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    PREADY    = 1'b0;
    PRDATA    = '0;
    last_rdata = '0;
    last_err   = 1'b0;
    for (int i = 0; i < 16; i++) begin
      ref_mem[i] = '0;
      slv_mem[i] = '0;
    end
    #1;
    n_total++;
    if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_rdata, rsp_err, req_ready} !==
        {4'b0000, {AW{1'b0}}, {DW{1'b0}}, 1'b0, {DW{1'b0}}, 1'b0, 1'b1})
      $display("FAIL reset: got %h want all zero, ready 1",
               {PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_rdata, rsp_err, req_ready});
    else n_pass++;
    @(posedge PCLK); @(posedge PCLK); #1;
    PRESETn = 1'b1;
    @(posedge PCLK); #1;
  endtask

  task automatic test_write_basic();
    do_xfer(1'b1, 32'h3, 32'hDEAD_BEEF, 0, 1'b1, "wr_basic");
  endtask

  task automatic test_read_wait();
    ref_mem[5] = 32'h1234_5678;
    slv_mem[5] = 32'h1234_5678;
    do_xfer(1'b0, 32'h5, $urandom, 3, 1'b0, "rd_wait");
  endtask

  task automatic test_setup_ready();
    do_xfer(1'b0, 32'h3, $urandom, 2, 1'b1, "setup_rdy");
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] wd [2];
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    wd[0] = $urandom;
    wd[1] = $urandom;
    ref_mem[1] = wd[0];
    ref_mem[2] = wd[1];
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 32'h1;
    req_wdata = wd[0];
    PREADY    = 1'b1;
    @(posedge PCLK); #1;
    req_addr  = 32'h2;
    req_wdata = wd[1];
    // Cycle k after the first accept: phase 0 SETUP, 1 ACCESS, 2 response/idle.
    for (int k = 0; k < 6; k++) begin
      ea = 32'(1 + k / 3);
      ed = wd[k / 3];
      @(negedge PCLK);
      n_total++;
      if ({PSEL, PENABLE, PADDR, PWDATA, rsp_valid, req_ready} !==
          {(k % 3) != 2, (k % 3) == 1, ea, ed, (k % 3) == 2, (k % 3) == 2})
        $display("FAIL b2b k%0d: got %h want %h", k,
                 {PSEL, PENABLE, PADDR, PWDATA, rsp_valid, req_ready},
                 {(k % 3) != 2, (k % 3) == 1, ea, ed, (k % 3) == 2, (k % 3) == 2});
      else n_pass++;
      if (k % 3 == 1 && PWRITE) slv_mem[PADDR[3:0]] = PWDATA;
      if (k % 3 == 2) begin
        n_total++;
        if ({rsp_rdata, rsp_err} !== {{DW{1'b0}}, 1'b0})
          $display("FAIL b2b rsp k%0d: got %h want 0", k, {rsp_rdata, rsp_err});
        else n_pass++;
      end
      @(posedge PCLK); #1;
      if (k == 2) req_valid = 1'b0;
    end
    PREADY = 1'b0;
    last_rdata = '0;
    last_err   = 1'b0;
  endtask

  task automatic test_timeout();
    logic [DW-1:0] rd;
    rd = ref_mem[7];
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 32'h7;
    req_wdata = 32'h0;
    @(posedge PCLK); #1;
    req_valid = 1'b0;
    PREADY    = 1'b0;
    @(negedge PCLK);
    @(posedge PCLK); #1;
    for (int i = 0; i < 8; i++) begin
      @(negedge PCLK);
      n_total++;
`ifdef APB_MASTER_TIMEOUT_EN
      if (i < TO) begin
        if ({PSEL, PENABLE, PADDR, rsp_valid} !== {1'b1, 1'b1, 32'h7, 1'b0})
          $display("FAIL timeout wait%0d: got %h want %h", i,
                   {PSEL, PENABLE, PADDR, rsp_valid}, {1'b1, 1'b1, 32'h7, 1'b0});
        else n_pass++;
      end else begin
        if ({PSEL, PENABLE, rsp_valid, rsp_err, rsp_rdata} !==
            {1'b0, 1'b0, i == TO, 1'b1, {DW{1'b0}}})
          $display("FAIL timeout abort%0d: got %h want %h", i,
                   {PSEL, PENABLE, rsp_valid, rsp_err, rsp_rdata},
                   {1'b0, 1'b0, i == TO, 1'b1, {DW{1'b0}}});
        else n_pass++;
      end
`else
      if ({PSEL, PENABLE, PADDR, rsp_valid, rsp_err} !== {1'b1, 1'b1, 32'h7, 1'b0, 1'b0})
        $display("FAIL timeout hold%0d: got %h want %h", i,
                 {PSEL, PENABLE, PADDR, rsp_valid, rsp_err}, {1'b1, 1'b1, 32'h7, 1'b0, 1'b0});
      else n_pass++;
`endif
      @(posedge PCLK); #1;
    end
`ifdef APB_MASTER_TIMEOUT_EN
    last_rdata = '0;
    last_err   = 1'b1;
`else
    PREADY = 1'b1;
    PRDATA = slv_mem[7];
    @(posedge PCLK); #1;
    PREADY = 1'b0;
    @(negedge PCLK);
    n_total++;
    if ({rsp_valid, rsp_rdata, PSEL} !== {1'b1, rd, 1'b0})
      $display("FAIL timeout late rsp: got %h want %h", {rsp_valid, rsp_rdata, PSEL},
               {1'b1, rd, 1'b0});
    else n_pass++;
    @(posedge PCLK); #1;
    last_rdata = rd;
    last_err   = 1'b0;
`endif
    do_xfer(1'b0, 32'h3, $urandom, 1, 1'b0, "after_timeout");
  endtask

  task automatic test_random();
    for (int t = 0; t < 24; t++) begin
      do_xfer(1'($urandom), $urandom, $urandom, int'($urandom_range(0, 3)),
              1'($urandom), "random");
    end
  endtask

  task automatic test_reset_mid();
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 32'h9;
    req_wdata = $urandom;
    @(posedge PCLK); #1;
    req_valid = 1'b0;
    PREADY    = 1'b0;
    @(posedge PCLK); #1;
    @(negedge PCLK);
    n_total++;
    if ({PSEL, PENABLE} !== 2'b11)
      $display("FAIL rst_mid pre: got %b want 11", {PSEL, PENABLE});
    else n_pass++;
    #2;
    PRESETn = 1'b0;
    #1;
    n_total++;
    if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_rdata, rsp_err, req_ready} !==
        {4'b0000, {AW{1'b0}}, {DW{1'b0}}, 1'b0, {DW{1'b0}}, 1'b0, 1'b1})
      $display("FAIL rst_mid async: got %h want all zero, ready 1",
               {PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_rdata, rsp_err, req_ready});
    else n_pass++;
    @(posedge PCLK); #1;
    PRESETn = 1'b1;
    last_rdata = '0;
    last_err   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge PCLK);
      n_total++;
      if ({PSEL, rsp_valid, req_ready} !== 3'b001)
        $display("FAIL rst_mid idle%0d: got %b want 001", i, {PSEL, rsp_valid, req_ready});
      else n_pass++;
      @(posedge PCLK); #1;
    end
    do_xfer(1'b0, 32'h5, $urandom, 1, 1'b0, "rst_fresh");
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    test_reset();
    test_write_basic();
    test_read_wait();
    test_back_to_back();
    test_setup_ready();
    test_timeout();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
